// File: rtl/cache_param_if.sv
// CPU-side and memory-side handshake bundle of the blocking cache.
// The slave view belongs to the cache; the master view drives it.
interface cache_param_if #(
    parameter int LINE_WORDS = 4
);
    logic                     valid;
    logic                     op;
    logic [31:0]              addr;
    logic [3:0]               wstrb;
    logic [31:0]              wdata;
    logic                     addr_ok;
    logic                     data_ok;
    logic [31:0]              rdata;
    logic                     rd_req;
    logic [2:0]               rd_type;
    logic [31:0]              rd_addr;
    logic                     rd_rdy;
    logic                     ret_valid;
    logic                     ret_last;
    logic [31:0]              ret_data;
    logic                     wr_req;
    logic [2:0]               wr_type;
    logic [31:0]              wr_addr;
    logic [3:0]               wr_wstrb;
    logic [32*LINE_WORDS-1:0] wr_data;
    logic                     wr_rdy;
    logic [31:0]              hit_cnt;
    logic [31:0]              miss_cnt;

    modport slave (
        input  valid, op, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        output addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr,
               wr_req, wr_type, wr_addr, wr_wstrb, wr_data, hit_cnt, miss_cnt
    );

    modport master (
        output valid, op, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
        input  addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr,
               wr_req, wr_type, wr_addr, wr_wstrb, wr_data, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_param.sv
// Blocking set-associative write-back cache with PLRU replacement, one request
// in flight, whole-line refill and dirty-victim writeback.
module cache_param #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         resetn,
    cache_param_if.slave bus
);
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WSEL_W = OFF_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        MISS    = 3'd2,
        REPLACE = 3'd3,
        REFILL  = 3'd4,
        RESPOND = 3'd5
    } state_t;

    state_t state_r, state_s;

    logic [TAG_W-1:0]  tag_r  [WAYS][SETS];
    logic [31:0]       data_r [WAYS][SETS][LINE_WORDS];
    logic [WAYS-1:0]   valid_r [SETS];
    logic [WAYS-1:0]   dirty_r [SETS];
    logic [2:0]        plru_r  [SETS];

    logic              op_r;
    logic [31:2]       addr_r;
    logic [3:0]        wstrb_r;
    logic [31:0]       wdata_r;
    logic [WAY_W-1:0]  vic_r;
    logic [WSEL_W-1:0] beat_r;
    logic [31:0]       hit_cnt_r, miss_cnt_r;

    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic [WSEL_W-1:0] wsel_s;
    logic [WAYS-1:0]   hit_vec_s;
    logic              hit_s;
    logic [WAY_W-1:0]  hit_way_s, inv_way_s, pick_s, rd_way_s;
    logic              vic_dirty_s;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    // Tree bit 0 picks the pair, bits 1/2 pick within the low/high pair; each bit names the victim side.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] way);
        logic [2:0] n;
        n = p;
        if (WAYS == 4) begin
            n[0] = ~way[1];
            if (way[1] == 1'b0) begin
                n[1] = ~way[0];
            end else begin
                n[2] = ~way[0];
            end
        end else begin
            n[0] = ~way[0];
        end
        return n;
    endfunction

    function automatic logic [1:0] plru_pick(input logic [2:0] p);
        logic [1:0] v;
        if (WAYS == 4) begin
            v = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
        end else begin
            v = {1'b0, p[0]};
        end
        return v;
    endfunction

    assign idx_s  = addr_r[OFF_W+IDX_W-1:OFF_W];
    assign tag_s  = addr_r[31:OFF_W+IDX_W];
    assign wsel_s = addr_r[OFF_W-1:2];

    // Tag compare and victim choice for the captured request.
    always_comb begin
        hit_way_s = '0;
        inv_way_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec_s[w] = valid_r[idx_s][w] && (tag_r[w][idx_s] == tag_s);
            hit_way_s    = hit_vec_s[w] ? WAY_W'(w) : hit_way_s;
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            inv_way_s = valid_r[idx_s][w] ? inv_way_s : WAY_W'(w);
        end
        hit_s       = |hit_vec_s;
        pick_s      = (&valid_r[idx_s]) ? WAY_W'(plru_pick(plru_r[idx_s])) : inv_way_s;
        vic_dirty_s = valid_r[idx_s][vic_r] && dirty_r[idx_s][vic_r];
        rd_way_s    = (state_r == RESPOND) ? vic_r : hit_way_s;
    end

    // Next-state and bus outputs.
    always_comb begin
        state_s      = state_r;
        bus.addr_ok  = (state_r == IDLE);
        bus.data_ok  = 1'b0;
        bus.rd_req   = 1'b0;
        bus.wr_req   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.valid) begin
                    state_s = LOOKUP;
                end else begin
                    state_s = IDLE;
                end
            end
            LOOKUP: begin
                bus.data_ok = hit_s;
                state_s     = hit_s ? IDLE : MISS;
            end
            MISS: begin
                if (vic_dirty_s) begin
                    bus.wr_req = 1'b1;
                    state_s    = bus.wr_rdy ? REPLACE : MISS;
                end else begin
                    state_s = REPLACE;
                end
            end
            REPLACE: begin
                bus.rd_req = 1'b1;
                state_s    = bus.rd_rdy ? REFILL : REPLACE;
            end
            REFILL: begin
                state_s = (bus.ret_valid && bus.ret_last) ? RESPOND : REFILL;
            end
            RESPOND: begin
                bus.data_ok = 1'b1;
                state_s     = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        bus.rdata    = bus.data_ok ? data_r[rd_way_s][idx_s][wsel_s] : 32'h0;
        bus.rd_type  = bus.rd_req ? 3'b100 : 3'b000;
        bus.rd_addr  = bus.rd_req ? {tag_s, idx_s, {OFF_W{1'b0}}} : 32'h0;
        bus.wr_type  = bus.wr_req ? 3'b100 : 3'b000;
        bus.wr_wstrb = bus.wr_req ? 4'hF : 4'h0;
        bus.wr_addr  = bus.wr_req ? {tag_r[vic_r][idx_s], idx_s, {OFF_W{1'b0}}} : 32'h0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            bus.wr_data[32*i +: 32] = bus.wr_req ? data_r[vic_r][idx_s][i] : 32'h0;
        end
    end

    assign bus.hit_cnt  = hit_cnt_r;
    assign bus.miss_cnt = miss_cnt_r;

    // Control state, line metadata and statistics.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            op_r       <= 1'b0;
            addr_r     <= '0;
            wstrb_r    <= 4'h0;
            wdata_r    <= 32'h0;
            vic_r      <= '0;
            beat_r     <= '0;
            hit_cnt_r  <= 32'h0;
            miss_cnt_r <= 32'h0;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                plru_r[s]  <= 3'b000;
            end
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (bus.valid) begin
                        op_r    <= bus.op;
                        addr_r  <= bus.addr[31:2];
                        wstrb_r <= bus.wstrb;
                        wdata_r <= bus.wdata;
                    end
                end
                LOOKUP: begin
                    beat_r <= '0;
                    if (hit_s) begin
                        plru_r[idx_s] <= plru_touch(plru_r[idx_s], 2'(hit_way_s));
                        if (op_r) begin
                            dirty_r[idx_s][hit_way_s] <= 1'b1;
                        end
                        if (hit_cnt_r != 32'hFFFF_FFFF) begin
                            hit_cnt_r <= hit_cnt_r + 32'd1;
                        end
                    end else begin
                        vic_r <= pick_s;
                        if (miss_cnt_r != 32'hFFFF_FFFF) begin
                            miss_cnt_r <= miss_cnt_r + 32'd1;
                        end
                    end
                end
                REFILL: begin
                    if (bus.ret_valid) begin
                        beat_r <= beat_r + 1'b1;
                        if (bus.ret_last) begin
                            valid_r[idx_s][vic_r] <= 1'b1;
                            dirty_r[idx_s][vic_r] <= op_r;
                            plru_r[idx_s]         <= plru_touch(plru_r[idx_s], 2'(vic_r));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data storage; contents are only meaningful once the valid bit is set.
    always_ff @(posedge clk) begin
        if (state_r == LOOKUP && hit_s && op_r) begin
            data_r[hit_way_s][idx_s][wsel_s] <=
                merge_word(data_r[hit_way_s][idx_s][wsel_s], wdata_r, wstrb_r);
        end
        if (state_r == REFILL && bus.ret_valid) begin
            data_r[vic_r][idx_s][beat_r] <= (op_r && beat_r == wsel_s) ?
                merge_word(bus.ret_data, wdata_r, wstrb_r) : bus.ret_data;
            if (bus.ret_last) begin
                tag_r[vic_r][idx_s] <= tag_s;
            end
        end
    end
endmodule

// File: tb/tb_cache_param.sv
// Directed table-driven bench for cache_param (WAYS=2, SETS=256, LINE_WORDS=4)
// with a small memory responder and hand sequences for reset and stray responses.
module tb_cache_param;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    cache_param_if #(.LINE_WORDS(4)) bus ();

    cache_param #(.WAYS(2), .SETS(256), .LINE_WORDS(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic             op;
        logic [31:0]      addr;
        logic [3:0]       wstrb;
        logic [31:0]      wdata;
        logic [3:0][31:0] beats;
        int               wr_delay;
        int               abort_beats;
        logic             exp_hit;
        logic             chk_rdata;
        logic [31:0]      exp_rdata;
        logic [31:0]      exp_rd_addr;
        logic             exp_wr;
        logic [31:0]      exp_wr_addr;
        logic [31:0]      exp_wr_w2;
        int               exp_hc;
        int               exp_mc;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic        o_hit, o_dok, o_rd_seen, o_wr_seen, o_perr, o_timeout, o_extra, o_aborted;
    logic [31:0] o_rdata, o_rd_addr, o_wr_addr, o_wr_w2;
    logic [2:0]  o_rd_type, o_wr_type;
    logic [3:0]  o_wr_wstrb;
    int          o_wr_cycles;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][31:0] seq4(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    function automatic vec_t mkv(input logic op, input logic [31:0] addr, input logic [3:0] wstrb,
                                 input logic [31:0] wdata, input logic [3:0][31:0] beats,
                                 input int wr_delay, input logic exp_hit, input logic chk_rdata,
                                 input logic [31:0] exp_rdata, input logic [31:0] exp_rd_addr,
                                 input logic exp_wr, input logic [31:0] exp_wr_addr,
                                 input logic [31:0] exp_wr_w2, input int hc, input int mc);
        vec_t v;
        v.op = op; v.addr = addr; v.wstrb = wstrb; v.wdata = wdata; v.beats = beats;
        v.wr_delay = wr_delay; v.abort_beats = 0;
        v.exp_hit = exp_hit; v.chk_rdata = chk_rdata; v.exp_rdata = exp_rdata;
        v.exp_rd_addr = exp_rd_addr; v.exp_wr = exp_wr; v.exp_wr_addr = exp_wr_addr;
        v.exp_wr_w2 = exp_wr_w2; v.exp_hc = hc; v.exp_mc = mc;
        return v;
    endfunction

    // Issue one request and play the memory side until data_ok, abort point or cycle budget.
    task automatic run_req(input vec_t v);
        int   cyc, beat, rd_cyc;
        logic done, rd_done, wr_done, in_refill;
        o_hit = 1'b0; o_dok = 1'b0; o_rd_seen = 1'b0; o_wr_seen = 1'b0; o_perr = 1'b0;
        o_timeout = 1'b0; o_extra = 1'b0; o_aborted = 1'b0; o_rdata = 32'h0;
        o_rd_addr = 32'h0; o_wr_addr = 32'h0; o_wr_w2 = 32'h0; o_rd_type = 3'b000;
        o_wr_type = 3'b000; o_wr_wstrb = 4'h0; o_wr_cycles = 0;
        cyc = 0; beat = 0; rd_cyc = 0;
        done = 1'b0; rd_done = 1'b0; wr_done = 1'b0; in_refill = 1'b0;
        @(negedge clk);
        chk("addr_ok_idle", {31'd0, bus.addr_ok}, 32'd1);
        bus.valid = 1'b1; bus.op = v.op; bus.addr = v.addr; bus.wstrb = v.wstrb; bus.wdata = v.wdata;
        @(negedge clk);
        bus.valid = 1'b0;
        while (!done && cyc < 200) begin
            if (bus.data_ok) begin
                o_dok = 1'b1; o_hit = (cyc == 0); o_rdata = bus.rdata; done = 1'b1;
            end else if (v.abort_beats != 0 && beat == v.abort_beats) begin
                o_aborted = 1'b1; done = 1'b1;
                bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
            end else begin
                if (bus.addr_ok) o_perr = 1'b1;
                if (bus.wr_req) begin
                    if (o_wr_seen && (bus.wr_addr != o_wr_addr || bus.wr_data[95:64] != o_wr_w2))
                        o_perr = 1'b1;
                    o_wr_seen = 1'b1; o_wr_cycles++;
                    o_wr_addr = bus.wr_addr; o_wr_w2 = bus.wr_data[95:64];
                    o_wr_type = bus.wr_type; o_wr_wstrb = bus.wr_wstrb;
                end
                if (bus.rd_req) begin
                    if ((o_wr_seen && !wr_done) || bus.wr_req) o_perr = 1'b1;
                    if (o_rd_seen && bus.rd_addr != o_rd_addr) o_perr = 1'b1;
                    o_rd_seen = 1'b1; rd_cyc++;
                    o_rd_addr = bus.rd_addr; o_rd_type = bus.rd_type;
                end
                bus.wr_rdy = bus.wr_req && (o_wr_cycles > v.wr_delay);
                if (bus.wr_rdy) wr_done = 1'b1;
                bus.rd_rdy = bus.rd_req && (rd_cyc >= 2);
                if (in_refill && beat < 4) begin
                    bus.ret_valid = 1'b1; bus.ret_data = v.beats[beat]; bus.ret_last = (beat == 3);
                    beat++;
                end else begin
                    bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
                end
                in_refill = rd_done;
                if (bus.rd_rdy) rd_done = 1'b1;
                cyc++;
                @(negedge clk);
            end
        end
        bus.wr_rdy = 1'b0; bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0;
        o_timeout = !done;
        if (done && !o_aborted) begin
            @(negedge clk);
            o_extra = bus.data_ok;
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        run_req(v);
        chk({tag, "_timeout"}, {31'd0, o_timeout}, 32'd0);
        chk({tag, "_hit"}, {31'd0, o_hit}, {31'd0, v.exp_hit});
        if (v.chk_rdata) chk({tag, "_rdata"}, o_rdata, v.exp_rdata);
        chk({tag, "_rd_req"}, {31'd0, o_rd_seen}, {31'd0, !v.exp_hit});
        if (!v.exp_hit) begin
            chk({tag, "_rd_addr"}, o_rd_addr, v.exp_rd_addr);
            chk({tag, "_rd_type"}, {29'd0, o_rd_type}, 32'd4);
        end
        chk({tag, "_wr_req"}, {31'd0, o_wr_seen}, {31'd0, v.exp_wr});
        if (v.exp_wr) begin
            chk({tag, "_wr_addr"}, o_wr_addr, v.exp_wr_addr);
            chk({tag, "_wr_word2"}, o_wr_w2, v.exp_wr_w2);
            chk({tag, "_wr_type"}, {29'd0, o_wr_type}, 32'd4);
            chk({tag, "_wr_wstrb"}, {28'd0, o_wr_wstrb}, 32'hF);
            chk({tag, "_wr_hold"}, {31'd0, o_wr_cycles > v.wr_delay}, 32'd1);
        end
        chk({tag, "_protocol"}, {31'd0, o_perr}, 32'd0);
        chk({tag, "_single_data_ok"}, {31'd0, o_extra}, 32'd0);
        chk({tag, "_hit_cnt"}, bus.hit_cnt, v.exp_hc);
        chk({tag, "_miss_cnt"}, bus.miss_cnt, v.exp_mc);
    endtask

    initial begin
        vec_t v;
        resetn = 1'b0;
        bus.valid = 1'b0; bus.op = 1'b0; bus.addr = 32'h0; bus.wstrb = 4'h0; bus.wdata = 32'h0;
        bus.rd_rdy = 1'b0; bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.ret_data = 32'h0;
        bus.wr_rdy = 1'b0;

        //                op    addr          wstrb wdata          beats                                                          wrd hit  chk  rdata          rd_addr        wr   wr_addr        wr_w2          hc mc
        vecs[0]  = mkv(1'b0, 32'h0000_1004, 4'h0, 32'h0,         {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 1'b0, 1'b1, 32'h2222_2222, 32'h0000_1000, 1'b0, 32'h0, 32'h0, 0, 1);
        vecs[1]  = mkv(1'b0, 32'h0000_1004, 4'h0, 32'h0,         '0,                  0, 1'b1, 1'b1, 32'h2222_2222, 32'h0,         1'b0, 32'h0, 32'h0, 1, 1);
        vecs[2]  = mkv(1'b1, 32'h0000_1008, 4'h3, 32'hFFFF_5678, '0,                  0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0, 32'h0, 2, 1);
        vecs[3]  = mkv(1'b0, 32'h0000_1008, 4'h0, 32'h0,         '0,                  0, 1'b1, 1'b1, 32'h3333_5678, 32'h0,         1'b0, 32'h0, 32'h0, 3, 1);
        vecs[4]  = mkv(1'b0, 32'h0000_2000, 4'h0, 32'h0,         seq4(32'hA000_0000), 0, 1'b0, 1'b1, 32'hA000_0000, 32'h0000_2000, 1'b0, 32'h0, 32'h0, 3, 2);
        vecs[5]  = mkv(1'b0, 32'h0000_2000, 4'h0, 32'h0,         '0,                  0, 1'b1, 1'b1, 32'hA000_0000, 32'h0,         1'b0, 32'h0, 32'h0, 4, 2);
        vecs[6]  = mkv(1'b0, 32'h0000_3000, 4'h0, 32'h0,         seq4(32'hB000_0000), 5, 1'b0, 1'b1, 32'hB000_0000, 32'h0000_3000, 1'b1, 32'h0000_1000, 32'h3333_5678, 4, 3);
        vecs[7]  = mkv(1'b0, 32'h0000_2008, 4'h0, 32'h0,         '0,                  0, 1'b1, 1'b1, 32'hA000_0002, 32'h0,         1'b0, 32'h0, 32'h0, 5, 3);
        vecs[8]  = mkv(1'b1, 32'h0000_5014, 4'hC, 32'hABCD_0000, seq4(32'hC000_0000), 0, 1'b0, 1'b1, 32'hABCD_0001, 32'h0000_5010, 1'b0, 32'h0, 32'h0, 5, 4);
        vecs[9]  = mkv(1'b0, 32'h0000_5014, 4'h0, 32'h0,         '0,                  0, 1'b1, 1'b1, 32'hABCD_0001, 32'h0,         1'b0, 32'h0, 32'h0, 6, 4);
        vecs[10] = mkv(1'b0, 32'h0000_501C, 4'h0, 32'h0,         '0,                  0, 1'b1, 1'b1, 32'hC000_0003, 32'h0,         1'b0, 32'h0, 32'h0, 7, 4);
        vecs[11] = mkv(1'b0, 32'h0000_6000, 4'h0, 32'h0,         seq4(32'hD000_0000), 0, 1'b0, 1'b1, 32'hD000_0000, 32'h0000_6000, 1'b0, 32'h0, 32'h0, 7, 5);
        vecs[12] = mkv(1'b0, 32'h0000_3000, 4'h0, 32'h0,         seq4(32'hE000_0000), 0, 1'b0, 1'b1, 32'hE000_0000, 32'h0000_3000, 1'b0, 32'h0, 32'h0, 7, 6);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_data_ok", {31'd0, bus.data_ok}, 32'd0);
        chk("rst_rd_req", {31'd0, bus.rd_req}, 32'd0);
        chk("rst_wr_req", {31'd0, bus.wr_req}, 32'd0);
        chk("rst_hit_cnt", bus.hit_cnt, 32'd0);
        chk("rst_miss_cnt", bus.miss_cnt, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            apply_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Stray memory responses while idle
        @(negedge clk);
        bus.ret_valid = 1'b1; bus.ret_last = 1'b1; bus.ret_data = 32'hDEAD_BEEF;
        bus.wr_rdy = 1'b1; bus.rd_rdy = 1'b1;
        @(negedge clk);
        chk("stray_data_ok", {31'd0, bus.data_ok}, 32'd0);
        chk("stray_addr_ok", {31'd0, bus.addr_ok}, 32'd1);
        chk("stray_rd_req", {31'd0, bus.rd_req}, 32'd0);
        bus.ret_valid = 1'b0; bus.ret_last = 1'b0; bus.wr_rdy = 1'b0; bus.rd_rdy = 1'b0;
        @(negedge clk);
        chk("stray_data_ok2", {31'd0, bus.data_ok}, 32'd0);
        chk("stray_hit_cnt", bus.hit_cnt, 32'd7);
        chk("stray_miss_cnt", bus.miss_cnt, 32'd6);
        apply_vec(mkv(1'b0, 32'h0000_6000, 4'h0, 32'h0, '0, 0, 1'b1, 1'b1, 32'hD000_0000,
                      32'h0, 1'b0, 32'h0, 32'h0, 8, 6), "post_stray");

        // Reset after two refill beats of a miss
        v = mkv(1'b0, 32'h0000_4000, 4'h0, 32'h0, seq4(32'h9000_0000), 0, 1'b0, 1'b0, 32'h0,
                32'h0000_4000, 1'b0, 32'h0, 32'h0, 0, 0);
        v.abort_beats = 2;
        run_req(v);
        chk("abort_reached", {31'd0, o_aborted}, 32'd1);
        chk("abort_no_data_ok", {31'd0, o_dok}, 32'd0);
        chk("abort_rd_addr", o_rd_addr, 32'h0000_4000);
        resetn = 1'b0;
        #1;
        chk("mid_rst_rd_req", {31'd0, bus.rd_req}, 32'd0);
        chk("mid_rst_rd_addr", bus.rd_addr, 32'd0);
        chk("mid_rst_wr_req", {31'd0, bus.wr_req}, 32'd0);
        chk("mid_rst_data_ok", {31'd0, bus.data_ok}, 32'd0);
        chk("mid_rst_rdata", bus.rdata, 32'd0);
        chk("mid_rst_hit_cnt", bus.hit_cnt, 32'd0);
        chk("mid_rst_miss_cnt", bus.miss_cnt, 32'd0);
        @(negedge clk);
        chk("mid_rst_data_ok2", {31'd0, bus.data_ok}, 32'd0);
        resetn = 1'b1;
        apply_vec(mkv(1'b0, 32'h0000_4000, 4'h0, 32'h0, seq4(32'hF000_0000), 0, 1'b0, 1'b1,
                      32'hF000_0000, 32'h0000_4000, 1'b0, 32'h0, 32'h0, 0, 1), "rerun_4000");
        apply_vec(mkv(1'b0, 32'h0000_6000, 4'h0, 32'h0, seq4(32'h7000_0000), 0, 1'b0, 1'b1,
                      32'h7000_0000, 32'h0000_6000, 1'b0, 32'h0, 32'h0, 0, 2), "post_rst_6000");
        apply_vec(mkv(1'b0, 32'h0000_4004, 4'h0, 32'h0, '0, 0, 1'b1, 1'b1,
                      32'hF000_0001, 32'h0, 1'b0, 32'h0, 32'h0, 1, 2), "hit_4004");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_param.md
CACHE_PARAM -- requirements
Module: cache_param

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 SHALL have parameter SETS, default 256, number of sets; power of two, 16..256.
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line; legal values 4, 8.
REQ-004 SHALL derive OFF_W=log2(LINE_WORDS)+2, IDX_W=log2(SETS) and TAG_W=32-OFF_W-IDX_W; addr[OFF_W-1:0] is offset, the next IDX_W bits are index, the rest is tag.
REQ-005 SHALL have ports:
  clk  in  1  clock
  resetn  in  1  reset (one clock; reset is asynchronous and active-low)
  valid  in  1  CPU request
  op  in  1  0 read, 1 write
  addr  in  32  byte address
  wstrb  in  4  byte enables (write)
  wdata  in  32  write data
  addr_ok  out  1  request accepted
  data_ok  out  1  response valid
  rdata  out  32  read data
  rd_req  out  1  line refill request
  rd_type  out  3  refill type
  rd_addr  out  32  line-aligned refill address
  rd_rdy  in  1  refill request accepted
  ret_valid  in  1  refill beat valid
  ret_last  in  1  final refill beat
  ret_data  in  32  refill beat data
  wr_req  out  1  victim writeback request
  wr_type  out  3  writeback type
  wr_addr  out  32  line-aligned victim address
  wr_wstrb  out  4  writeback byte enables
  wr_data  out  32*LINE_WORDS  victim line, word 0 in LSBs
  wr_rdy  in  1  writeback accepted
  hit_cnt  out  32  hit count
  miss_cnt  out  32  miss count

Function
REQ-006 SHALL be blocking: FSM states IDLE, LOOKUP, MISS, REPLACE, REFILL, RESPOND; one request in flight.
REQ-007 SHALL drive addr_ok=1 only in IDLE; valid&&addr_ok captures op/addr/wstrb/wdata and moves to LOOKUP; valid outside IDLE is ignored.
REQ-008 LOOKUP: hit = any way with valid set and stored tag equal to request tag.
REQ-009 On hit: data_ok=1 for exactly that cycle (one cycle after acceptance); rdata = hit word for reads; writes merge wdata byte-wise per wstrb at the clock edge and set dirty; PLRU updated; hit_cnt+1; next state IDLE.
REQ-010 On miss: select the victim (lowest-index invalid way, else the PLRU way); miss_cnt+1; next state MISS.
REQ-011 MISS: if victim valid and dirty, hold wr_req=1, wr_type=3'b100, wr_wstrb=4'hF, wr_addr={victim tag, index, OFF_W'b0}, and wr_data stable until the cycle wr_rdy=1, then REPLACE; if clean, go directly to REPLACE without asserting wr_req.
REQ-012 REPLACE: hold rd_req=1, rd_type=3'b100, rd_addr={tag, index, OFF_W'b0} stable until rd_rdy=1, then REFILL.
REQ-013 REFILL: beat counter starts at 0; each ret_valid writes ret_data to word[counter] of the victim way; for a write request, the target word is merged with wdata per wstrb as it is written.
REQ-014 The beat with ret_last=1 SHALL set valid, set tag, set dirty=op, update PLRU, and move to RESPOND.
REQ-015 RESPOND: data_ok=1 for one cycle; rdata = final content of the requested word; next state IDLE.
REQ-016 PLRU: WAYS=1 has none; WAYS=2 uses one bit per set; WAYS=4 uses a 3-bit tree per set. On hit or refill, the bits on the accessed way's path point away from that way.
REQ-017 ret_valid outside REFILL and wr_rdy/rd_rdy outside their states SHALL be ignored.
REQ-018 hit_cnt and miss_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-019 rdata SHALL be don't-care when data_ok=0.

Reset
REQ-020 resetn low SHALL asynchronously force: state IDLE, all valid, dirty and PLRU bits 0, counters 0, every request/response output 0; tag and data arrays are not reset.
REQ-021 Reset during any state, including mid-refill, SHALL discard the request; no data_ok is produced and the partially filled line stays invalid.

Verification (WAYS=2, SETS=256, LINE_WORDS=4)
REQ-022 Cold read 0x0000_1004, refill beats 0x1111_1111, 0x2222_2222, 0x3333_3333, 0x4444_4444 (last on beat 4) -> rd_addr 0x0000_1000, rd_type 100, no wr_req, data_ok with rdata 0x2222_2222, miss_cnt 1.
REQ-023 Then read 0x0000_1004 -> data_ok one cycle after addr_ok, rdata 0x2222_2222, no rd_req, hit_cnt 1.
REQ-024 Write 0x0000_1008, wstrb 0011, wdata 0xFFFF_5678, then read 0x0000_1008 -> rdata 0x3333_5678.
REQ-025 Fill tag 0x2000 in set 0, read 0x0000_2000, then read 0x0000_3000 with wr_rdy held low 5 cycles -> wr_req held 5+ cycles with wr_addr 0x0000_1000 and wr_data word2 0x3333_5678; rd_req for 0x0000_3000 only after the wr handshake.
REQ-026 Assert resetn low after 2 refill beats of a miss to 0x0000_4000 -> outputs 0 immediately; re-read of 0x0000_4000 misses again with a fresh rd_req.
REQ-027 Pulse ret_valid and ret_last in IDLE -> no state change, no data_ok, counters unchanged.
